instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Sits directly downstream of the program counter in the TSC CPU front end.
- Takes the current PC value, issues a handshaked read to instruction memory, and buffers the returned word.
- Presents the word to decode with a valid/ready handshake.
- Pulses a one-cycle advance strobe to the PC when decode accepts the word.
- Discards in-flight fetches on a redirect (jump).

Parameters:
WORD_SIZE, 16, instruction and address width.
TIMEOUT_CYCLES, 255, wait-cycle limit for a memory response; used only with FETCH_TIMEOUT_EN.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high reset.
pc_addr  in  WORD_SIZE  current PC value.
pc_advance  out  1  combinational; high for one cycle when decode accepts the held word.
redirect  in  1  jump taken; kills the outstanding fetch or held word.
mem_readM  out  1  memory read request.
mem_address  out  WORD_SIZE  memory read address.
mem_data  in  WORD_SIZE  read data; valid when mem_inputReady=1.
mem_inputReady  in  1  memory response strobe, one cycle.
inst_valid  out  1  held instruction is valid.
inst  out  WORD_SIZE  held instruction word.
inst_pc  out  WORD_SIZE  address the held word was fetched from.
inst_ready  in  1  decode accepts the word.
fetch_err  out  1  sticky timeout flag; constant 0 without FETCH_TIMEOUT_EN.

Behaviour:
- Reset values: state IDLE; mem_readM, mem_address, inst_valid, inst, inst_pc and fetch_err all 0.
- All state and registered outputs update on the rising clk edge.
- IDLE (one cycle):
  - mem_address <= pc_addr, mem_readM <= 1, go to REQ.
  - redirect is ignored in IDLE; pc_addr is sampled fresh.
- REQ:
  - mem_readM and mem_address are held stable until mem_inputReady=1.
  - On mem_inputReady with no redirect: inst <= mem_data, inst_pc <= mem_address, inst_valid <= 1, mem_readM <= 0, go to HOLD.
  - On redirect with no mem_inputReady: go to DISCARD; the request stays asserted, because memory requests cannot be withdrawn.
  - On redirect and mem_inputReady in the same cycle: drop the data, mem_readM <= 0, go to IDLE.
- DISCARD:
  - Keep mem_readM=1 until mem_inputReady, then drop the data, mem_readM <= 0, go to IDLE.
  - Further redirects in DISCARD are absorbed.
- HOLD:
  - inst, inst_pc and inst_valid are stable while inst_ready=0.
  - pc_advance = (state==HOLD) & inst_valid & inst_ready & ~redirect.
  - On acceptance: inst_valid <= 0, go to IDLE. The PC increments on the same edge, so IDLE samples the new pc_addr.
  - redirect has priority over inst_ready: inst_valid <= 0, no pc_advance, go to IDLE. The PC is loaded with the jump target by its own logic.
- Throughput: minimum 3 cycles per instruction (IDLE, REQ with 1-cycle memory, HOLD with immediate ready).
- Reset asserted mid-fetch returns to IDLE immediately. Any late mem_inputReady is ignored because mem_readM is already 0.
- inst_valid never rises without a matching mem_inputReady while in REQ.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With the macro:
  - An 8-bit wait counter clears on entry to REQ/DISCARD and increments each cycle there with mem_inputReady=0.
  - On reaching TIMEOUT_CYCLES: fetch_err <= 1 (sticky until reset), mem_readM <= 0, inst_valid stays 0, go to IDLE.
  - Fetching then retries normally.
- Without the macro:
  - No counter is built; fetch_err is tied to 0 and the unit waits indefinitely.

Decomposition:
- Shared constants header: WORD_SIZE, the 2-bit FSM state encodings (IDLE=0, REQ=1, HOLD=2, DISCARD=3), and the default TIMEOUT_CYCLES.
- One natural sub-module: fetch_timeout_counter (clear, enable, terminal-count output), instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- pc_addr=0x0000, memory replies 1 cycle after request with 0xA123, inst_ready=1 -> mem_address=0x0000; inst=0xA123, inst_pc=0x0000; one pc_advance pulse; next request to 0x0001; 3-cycle cadence.
- Memory latency 4 cycles, inst_ready held 0 for 5 cycles after valid -> mem_readM and mem_address stable throughout REQ; inst stable throughout HOLD; exactly one pc_advance.
- redirect pulsed in REQ, mem_inputReady arrives 2 cycles later with 0xBEEF -> no inst_valid; mem_readM held until the response; next request uses the new pc_addr (e.g. 0x0ABC).
- redirect and inst_ready both high in HOLD -> pc_advance=0, inst_valid falls, returns to IDLE.
- Reset asserted while in REQ, then a stray mem_inputReady -> all outputs 0; the stray response is ignored; refetch from 0x0000 after reset release.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=8, memory never responds -> mem_readM drops after 8 wait cycles; fetch_err=1 and stays 1; the retry request is issued from IDLE.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared widths, FSM state encodings and timeout default for the fetch unit.
package instruction_fetch_unit_pkg;
    localparam int IFU_WORD_SIZE      = 16;
    localparam int IFU_TIMEOUT_CYCLES = 255;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;
endpackage

// File: rtl/instruction_fetch_unit_timeout_counter.sv
// fetch_timeout_counter: 8-bit wait counter; tc_o flags the LIMIT-th consecutive enabled cycle.
module fetch_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    always_comb cnt_d = clear_i ? 8'd0 : (enable_i ? cnt_q + 8'd1 : cnt_q);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= 8'd0;
        else       cnt_q <= cnt_d;
    end
    assign tc_o = enable_i && (cnt_q == 8'(LIMIT - 1));
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches the word at pc_addr from memory and hands it to decode via valid/ready.
// Define FETCH_TIMEOUT_EN to abandon fetches after TIMEOUT_CYCLES wait cycles and raise sticky fetch_err.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int WORD_SIZE = IFU_WORD_SIZE
`ifdef FETCH_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = IFU_TIMEOUT_CYCLES
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] pc_addr,
    output logic                 pc_advance,
    input  logic                 redirect,
    output logic                 mem_readM,
    output logic [WORD_SIZE-1:0] mem_address,
    input  logic [WORD_SIZE-1:0] mem_data,
    input  logic                 mem_inputReady,
    output logic                 inst_valid,
    output logic [WORD_SIZE-1:0] inst,
    output logic [WORD_SIZE-1:0] inst_pc,
    input  logic                 inst_ready,
    output logic                 fetch_err
);
    fetch_state_e         state_q, state_d;
    logic                 read_q, read_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic                 valid_q, valid_d;
    logic [WORD_SIZE-1:0] inst_q, inst_d;
    logic [WORD_SIZE-1:0] inst_pc_q, inst_pc_d;
    logic                 err_q, err_d;
    logic                 timeout;

`ifdef FETCH_TIMEOUT_EN
    // Any state change restarts the count, so entering REQ or DISCARD always begins from zero.
    fetch_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_d != state_q),
        .enable_i ((state_q == REQ || state_q == DISCARD) && !mem_inputReady),
        .tc_o     (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        read_d    = read_q;
        addr_d    = addr_q;
        valid_d   = valid_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                addr_d  = pc_addr;
                read_d  = 1'b1;
                state_d = REQ;
            end
            REQ: begin
                if (mem_inputReady) begin
                    read_d = 1'b0;
                    if (redirect) begin
                        state_d = IDLE;
                    end else begin
                        inst_d    = mem_data;
                        inst_pc_d = addr_q;
                        valid_d   = 1'b1;
                        state_d   = HOLD;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    read_d  = 1'b0;
                    state_d = IDLE;
                end else if (redirect) begin
                    state_d = DISCARD;
                end
            end
            HOLD: begin
                if (redirect || inst_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                // The request cannot be withdrawn, so wait out the response and drop it.
                if (mem_inputReady || timeout) begin
                    err_d   = err_q | (timeout & ~mem_inputReady);
                    read_d  = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            read_q    <= 1'b0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            read_q    <= read_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            err_q     <= err_d;
        end
    end

    assign pc_advance  = (state_q == HOLD) && valid_q && inst_ready && !redirect;
    assign mem_readM   = read_q;
    assign mem_address = addr_q;
    assign inst_valid  = valid_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign fetch_err   = err_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed bench; expected fetched words are queued and checked when inst_valid rises.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc_addr = '0;
  logic        pc_advance;
  logic        redirect = 1'b0;
  logic        mem_readM;
  logic [15:0] mem_address;
  logic [15:0] mem_data = '0;
  logic        mem_inputReady = 1'b0;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        fetch_err;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc = 0;
  int prev_req = 0;
  logic prev_valid = 1'b0;
  logic [31:0] sb[$];
  logic [31:0] exp_word;
`ifdef FETCH_TIMEOUT_EN
  instruction_fetch_unit #(.TIMEOUT_CYCLES(8)) dut (.*);
`else
  instruction_fetch_unit dut (.*);
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  always @(negedge clk) begin
    if (inst_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {16'h0, inst}, 32'hFFFF_FFFF);
      end else begin
        exp_word = sb.pop_front();
        chk("sb_inst", {inst_pc, inst}, exp_word);
      end
    end
    prev_valid = inst_valid;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start_req(input logic [15:0] pc);
    pc_addr = pc;
    step();
    prev_req = req_cyc;
    req_cyc = cyc;
    chk("req_readM", {31'h0, mem_readM}, 32'h1);
    chk("req_addr", {16'h0, mem_address}, {16'h0, pc});
  endtask
  task automatic finish(input logic [15:0] pc, input logic [15:0] data, input int lat, input int hold);
    for (int i = 1; i < lat; i++) begin
      step();
      chk("wait_readM", {31'h0, mem_readM}, 32'h1);
      chk("wait_addr", {16'h0, mem_address}, {16'h0, pc});
      chk("wait_valid", {31'h0, inst_valid}, 32'h0);
    end
    mem_inputReady = 1'b1;
    mem_data = data;
    sb.push_back({pc, data});
    step();
    mem_inputReady = 1'b0;
    mem_data = 16'hxxxx;
    chk("hold_valid", {31'h0, inst_valid}, 32'h1);
    chk("hold_readM", {31'h0, mem_readM}, 32'h0);
    for (int i = 0; i < hold; i++) begin
      chk("hold_noadv", {31'h0, pc_advance}, 32'h0);
      step();
      chk("hold_stable", {inst_pc, inst}, {pc, data});
      chk("hold_valid_stable", {31'h0, inst_valid}, 32'h1);
    end
    inst_ready = 1'b1;
    #1;
    chk("advance", {31'h0, pc_advance}, 32'h1);
    step();
    inst_ready = 1'b0;
    chk("post_valid", {31'h0, inst_valid}, 32'h0);
    chk("post_adv", {31'h0, pc_advance}, 32'h0);
  endtask
  initial begin
    step();
    step();
    chk("rst_outputs", {mem_readM, inst_valid, fetch_err, pc_advance, 28'h0}, 32'h0);
    chk("rst_regs", {mem_address, inst}, 32'h0);
    chk("rst_inst_pc", {16'h0, inst_pc}, 32'h0);
    reset = 1'b0;
    start_req(16'h0000);
    finish(16'h0000, 16'hA123, 1, 0);
    start_req(16'h0001);
    chk("cadence", req_cyc - prev_req, 32'd3);
    finish(16'h0001, 16'h5A5A, 1, 0);
    start_req(16'h0002);
    finish(16'h0002, 16'h1234, 4, 5);
    start_req(16'h0100);
    redirect = 1'b1;
    step();
    redirect = 1'b0;
    pc_addr = 16'h0ABC;
    chk("disc_readM", {31'h0, mem_readM}, 32'h1);
    chk("disc_addr", {16'h0, mem_address}, 32'h0100);
    redirect = 1'b1;
    step();
    redirect = 1'b0;
    chk("disc_readM2", {31'h0, mem_readM}, 32'h1);
    mem_inputReady = 1'b1;
    mem_data = 16'hBEEF;
    step();
    mem_inputReady = 1'b0;
    chk("disc_drop", {mem_readM, inst_valid}, 32'h0);
    start_req(16'h0ABC);
    finish(16'h0ABC, 16'hC0DE, 1, 0);
    start_req(16'h0200);
    redirect = 1'b1;
    mem_inputReady = 1'b1;
    mem_data = 16'hDEAD;
    step();
    redirect = 1'b0;
    mem_inputReady = 1'b0;
    chk("both_drop", {mem_readM, inst_valid}, 32'h0);
    start_req(16'h0300);
    mem_inputReady = 1'b1;
    mem_data = 16'h7777;
    sb.push_back({16'h0300, 16'h7777});
    step();
    mem_inputReady = 1'b0;
    inst_ready = 1'b1;
    redirect = 1'b1;
    #1;
    chk("redir_noadv", {31'h0, pc_advance}, 32'h0);
    step();
    inst_ready = 1'b0;
    redirect = 1'b0;
    chk("redir_valid", {31'h0, inst_valid}, 32'h0);
    start_req(16'h0400);
    finish(16'h0400, 16'h4444, 2, 1);
    start_req(16'h0500);
    step();
    reset = 1'b1;
    #1;
    chk("arst_outputs", {mem_readM, inst_valid, fetch_err, pc_advance, 28'h0}, 32'h0);
    chk("arst_regs", {mem_address, inst}, 32'h0);
    mem_inputReady = 1'b1;
    mem_data = 16'hFFFF;
    step();
    mem_inputReady = 1'b0;
    chk("stray_ignored", {mem_readM, inst_valid, 30'h0}, 32'h0);
    reset = 1'b0;
    start_req(16'h0000);
    finish(16'h0000, 16'h0F0F, 1, 0);
`ifdef FETCH_TIMEOUT_EN
    start_req(16'h0600);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("to_waiting", {mem_readM, fetch_err, 30'h0}, {2'b10, 30'h0});
    end
    step();
    chk("to_fired", {mem_readM, fetch_err, inst_valid, 29'h0}, {3'b010, 29'h0});
    start_req(16'h0600);
    chk("to_sticky", {31'h0, fetch_err}, 32'h1);
    finish(16'h0600, 16'h6666, 1, 0);
    chk("to_sticky2", {31'h0, fetch_err}, 32'h1);
`else
    chk("no_err", {31'h0, fetch_err}, 32'h0);
`endif
    step();
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
